// File: rtl/bram_rr_controller_pkg.sv
// rtl/bram_rr_controller_pkg.sv - shared state type and address-width helper for the BRAM controller
package bram_ctrl_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } ctrl_state_e;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bram_rr_controller_rr_arbiter.sv
// rtl/bram_rr_controller_rr_arbiter.sv - round-robin one-hot arbiter owning the rotation pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] ptr_next;

  // Walk from the farthest candidate back to rr_ptr so the nearest requester wins.
  always_comb begin
    grant    = '0;
    ptr_next = rr_ptr;
    if (advance) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant = '0;
          grant[(int'(rr_ptr) + k) % NUM_REQ] = 1'b1;
          ptr_next = PW'((int'(rr_ptr) + k + 1) % NUM_REQ);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/bram_rr_controller.sv
// rtl/bram_rr_controller.sv - zero-fill, round-robin read and write front end for one dual-port BRAM
// Optional write-to-read bypass: BRAM_CTRL_WR_BYPASS_EN
module bram_rr_controller
  import bram_ctrl_pkg::*;
#(
  parameter  int WORD_LEN = 32,
  parameter  int DEPTH    = 256,
  parameter  int NUM_REQ  = 4,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  init_done,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [WORD_LEN-1:0]   rsp_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_LEN-1:0]   wr_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [AW-1:0]         ram_addra,
  output logic [WORD_LEN-1:0]   ram_dia,
  output logic                  ram_enb,
  output logic [AW-1:0]         ram_addrb,
  input  logic [WORD_LEN-1:0]   ram_dob
);

  ctrl_state_e        state;
  logic [AW-1:0]      fill_addr;
  logic [NUM_REQ-1:0] grant;
  logic               run;

  assign run = (state == S_RUN);

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (run),
    .grant   (grant)
  );

  assign req_ready = grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_INIT;
      fill_addr <= '0;
      init_done <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (fill_addr == AW'(DEPTH - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
          end else begin
            fill_addr <= fill_addr + AW'(1);
          end
        end
        S_RUN: begin
          if (clr) begin
            state     <= S_INIT;
            fill_addr <= '0;
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Fill writes are gated by rst_n so port A stays quiet while reset is held.
  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 1'b0;
    ram_addra = '0;
    ram_dia   = '0;
    if (!run) begin
      ram_ena   = rst_n;
      ram_wea   = rst_n;
      ram_addra = fill_addr;
    end else begin
      ram_ena   = wr_valid;
      ram_wea   = wr_valid;
      ram_addra = wr_addr;
      ram_dia   = wr_data;
    end
  end

  always_comb begin
    ram_addrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) ram_addrb = req_addr[i*AW +: AW];
    end
  end

  assign ram_enb = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_valid <= '0;
    else        rsp_valid <= grant;
  end

`ifdef BRAM_CTRL_WR_BYPASS_EN
  logic                byp_hit;
  logic [WORD_LEN-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= run && wr_valid && ram_enb && (wr_addr == ram_addrb);
      byp_data <= wr_data;
    end
  end

  assign rsp_data = (rsp_valid == '0) ? '0 : (byp_hit ? byp_data : ram_dob);
`else
  assign rsp_data = (rsp_valid == '0) ? '0 : ram_dob;
`endif

endmodule

// File: tb/tb_bram_rr_controller.sv
// tb/tb_bram_rr_controller.sv - randomized, model-checked bench for bram_rr_controller
module tb_bram_rr_controller;

  localparam int WL    = 32;
  localparam int DEPTH = 8;
  localparam int N     = 4;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          init_done;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [WL-1:0] rsp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [WL-1:0] wr_data;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [WL-1:0] ram_dia;
  logic [WL-1:0] ram_dob = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_rr_controller #(.WORD_LEN(WL), .DEPTH(DEPTH), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .init_done(init_done),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  // Physical RAM: read-first, registered port B, starts with non-zero junk.
  logic [WL-1:0] ram [DEPTH] = '{default: 32'hA5A5_5A5A};
  always @(posedge clk) begin
    if (ram_enb) ram_dob <= ram[ram_addrb];
    if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract controller state, shadow memory, expected responses.
  bit            m_run;
  int            m_fill, m_ptr, gidx, raddr;
  logic [WL-1:0] mem_m [DEPTH];
  logic [N-1:0]  e_rv, eg;
  logic [WL-1:0] e_rd, rdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_ram_en", {ram_ena, ram_wea, ram_enb}, 0);
      m_run = 0; m_fill = 0; m_ptr = 0; e_rv = '0; e_rd = '0;
    end else begin
      gidx = -1;
      if (m_run)
        for (int k = 0; k < N; k++)
          if (gidx < 0 && req_valid[(m_ptr + k) % N]) gidx = (m_ptr + k) % N;
      eg = '0;
      if (gidx >= 0) eg[gidx] = 1'b1;
      chk("req_ready", req_ready, eg);
      chk("init_done", init_done, m_run);
      chk("wr_ready", wr_ready, m_run);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv != '0) chk("rsp_data", rsp_data, e_rd);
      chk("ram_ena", ram_ena, m_run ? wr_valid : 1'b1);
      chk("ram_wea", ram_wea, m_run ? wr_valid : 1'b1);
      if (!m_run) begin
        chk("fill_addra", ram_addra, m_fill);
        chk("fill_dia", ram_dia, 0);
      end else if (wr_valid) begin
        chk("wr_addra", ram_addra, wr_addr);
        chk("wr_dia", ram_dia, wr_data);
      end
      chk("ram_enb", ram_enb, gidx >= 0);
      rdata = '0;
      if (gidx >= 0) begin
        raddr = int'(req_addr[gidx*AW +: AW]);
        chk("ram_addrb", ram_addrb, raddr);
        rdata = mem_m[raddr];
`ifdef BRAM_CTRL_WR_BYPASS_EN
        if (wr_valid && int'(wr_addr) == raddr) rdata = wr_data;
`endif
        m_ptr = (gidx + 1) % N;
      end
      e_rv = eg;
      e_rd = rdata;
      if (!m_run) mem_m[m_fill] = '0;
      else if (wr_valid) mem_m[wr_addr] = wr_data;
      if (!m_run) begin
        if (m_fill == DEPTH - 1) m_run = 1;
        else m_fill++;
      end else if (clr) begin
        m_run = 0;
        m_fill = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!init_done) begin
      failures++;
      $display("FAIL init_timeout: init_done still %0b after %0d cycles", init_done, n);
    end
  endtask

  // Grant at the first negedge, response one cycle later; clears write/clr after the grant edge.
  task automatic do_read(input int r, input int a, input logic [WL-1:0] exp, input string nm);
    logic [N-1:0] g;
    g = '0;
    g[r] = 1'b1;
    req_valid = g;
    req_addr[r*AW +: AW] = AW'(a);
    @(negedge clk);
    chk({nm, "_grant"}, req_ready, g);
    step();
    req_valid = '0; wr_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk({nm, "_rsp_valid"}, rsp_valid, g);
    chk({nm, "_rsp_data"}, rsp_data, exp);
    step();
  endtask

  logic [N-1:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [N-1:0] g_now;

  initial begin
    clr = 1'b0; req_valid = '0; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < DEPTH; c++) begin
      @(negedge clk);
      chk("fill_wea", ram_wea, 1);
      chk("fill_addr_seq", ram_addra, c);
      chk("fill_init_low", init_done, 0);
    end
    @(negedge clk);
    chk("init_done_at_depth", init_done, 1);
    step();

    do_read(1, 5, 32'h0, "read_after_fill");

    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEAD_BEEF;
    step();
    wr_valid = 1'b0;
    do_read(2, 3, 32'hDEAD_BEEF, "wr_then_rd");

    wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 32'h1234_5678;
`ifdef BRAM_CTRL_WR_BYPASS_EN
    do_read(0, 7, 32'h1234_5678, "same_cycle_bypass");
`else
    do_read(0, 7, 32'h0, "same_cycle_old");
`endif

    wr_valid = 1'b1; wr_addr = 3'd4; wr_data = 32'hCAFE_0004;
    step();
    wr_valid = 1'b0;
    clr = 1'b1;
    do_read(3, 4, 32'hCAFE_0004, "clr_rd");
    for (int c = 1; c < DEPTH; c++) begin
      @(negedge clk);
      chk("clr_fill_addr", ram_addra, c);
      chk("clr_init_low", init_done, 0);
    end
    @(negedge clk);
    chk("clr_init_rise", init_done, 1);
    step();
    do_read(0, 3, 32'h0, "clr_zeroed_3");
    do_read(1, 4, 32'h0, "clr_zeroed_4");

    req_valid = 4'b0100;
    @(negedge clk);
    chk("pre_rst_grant", req_ready, 4'b0100);
    step();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_drops_rsp", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_init(DEPTH + 4);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      chk("rr_seq_grant", req_ready, seq[c]);
      if (c > 0) chk("rr_seq_rsp", rsp_valid, seq[c-1]);
      step();
    end
    req_valid = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      g_now = req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || g_now[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 60);
          req_addr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        end
      end
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      clr      = ($urandom_range(0, 99) == 0);
    end
    req_valid = '0; wr_valid = 1'b0; clr = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/bram_rr_controller.md
# bram_rr_controller

Round-robin controller sharing one simple dual-port block RAM among `NUM_REQ` read requesters and one write requester in the raytracer datapath. It zero-fills the RAM after reset or on request, then arbitrates reads onto port B and returns each word one cycle after issue. It forwards writes onto port A and owns every RAM control signal.

## Interface
- `WORD_LEN`, 32, RAM word width in bits
- `DEPTH`, 256, RAM word count; power of two, ≥ 2; `AW = $clog2(DEPTH)`
- `NUM_REQ`, 4, number of read requesters; ≥ 2
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `clr` in 1: one-cycle pulse; restarts the zero-fill
- `init_done` out 1: high once the zero-fill has finished
- `req_valid` in NUM_REQ: read request per requester
- `req_addr` in NUM_REQ*AW: packed addresses; requester i uses slice [i*AW +: AW]
- `req_ready` out NUM_REQ: one-hot grant
- `rsp_valid` out NUM_REQ: one-hot, marks the requester that owns `rsp_data`
- `rsp_data` out WORD_LEN: shared read data
- `wr_valid` in 1, `wr_ready` out 1, `wr_addr` in AW, `wr_data` in WORD_LEN: write channel
- `ram_ena`, `ram_wea` out 1; `ram_addra` out AW; `ram_dia` out WORD_LEN: RAM port A
- `ram_enb` out 1; `ram_addrb` out AW; `ram_dob` in WORD_LEN: RAM port B, registered, 1-cycle latency

## Operation
- States: `S_INIT` and `S_RUN`. Reset enters `S_INIT`.
- **S_INIT**
  - Sweep counter `fill_addr` runs 0..DEPTH-1, one address per cycle.
  - Port A drives `ram_ena=ram_wea=1`, `ram_addra=fill_addr`, `ram_dia=0`.
  - `req_ready=0`, `wr_ready=0`, `init_done=0`.
  - At `fill_addr==DEPTH-1`, go to `S_RUN` on the next edge.
- **S_RUN**
  - `init_done=1`, `wr_ready=1`.
  - Write handshake drives port A combinationally: `ram_ena=ram_wea=wr_valid`, `ram_addra=wr_addr`, `ram_dia=wr_data`.
  - `clr` seen in `S_RUN` moves to `S_INIT` with `fill_addr=0` on the next edge. `clr` during `S_INIT` is ignored.
- **Read arbitration (S_RUN only)**
  - Round-robin search starts at pointer `rr_ptr` and grants the first i with `req_valid[i]`.
  - `req_ready[i]` is high only for the granted i. It depends combinationally on `req_valid`.
  - Requesters must hold `req_valid`/`req_addr` stable until the grant.
  - On a grant: `ram_enb=1`, `ram_addrb=req_addr[i]`, and `rr_ptr <= (i+1) mod NUM_REQ`.
  - With no grant: `ram_enb=0` and `rr_ptr` holds.
- **Response**
  - Grant tag registered to `rsp_valid` one cycle later; `rsp_data=ram_dob`.
  - Responses cannot be stalled. Each requester must accept its response in that cycle.
- **Same-cycle write and read to the same address**: the RAM returns the old word (read-first), unless the macro below is set.

## Timing
- Read: grant at cycle T, `rsp_valid[i]` and data at T+1. Throughput is one read per cycle.
- Write: accepted at T, visible to a read granted at T+1 or later.
- Zero-fill: `init_done` rises exactly DEPTH cycles after `rst_n` deasserts, and DEPTH+1 cycles after a `clr` pulse.
- A read granted in the cycle `clr` pulses still returns its response at T+1.
- Reset values: `rsp_valid=0`, `rsp_data=0`, `req_ready=0`, `wr_ready=0`, `init_done=0`, `rr_ptr=0`, `fill_addr=0`, all `ram_*` enables 0.
- Reset asserted mid-operation drops any in-flight response (`rsp_valid=0` immediately) and restarts the fill. RAM contents are not reset directly; the fill rewrites them.
- `fill_addr` never wraps; it stops at DEPTH-1.

## Configuration
- `BRAM_CTRL_WR_BYPASS_EN` defined:
  - Registers a hit flag when a write and a granted read share an address in the same cycle, together with `wr_data`.
  - At T+1, `rsp_data` returns that written word instead of `ram_dob`.
- Undefined: `rsp_data=ram_dob` always (read-first old data). The bypass registers are absent.

## Structure
- Package `bram_ctrl_pkg`:
  - state enum `ctrl_state_e` {`S_INIT`, `S_RUN`}
  - helper function for `AW`
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`
  - inputs: request vector, `clk`, `rst_n`, advance
  - outputs: one-hot grant
  - owns `rr_ptr`
- The top holds the FSM, fill counter, response pipeline and bypass.

## Test plan
- Reset release, DEPTH=8 -> `ram_wea` high 8 cycles at addresses 0..7 with data 0. `init_done` rises at cycle 8. A read of address 5 then returns 0.
- Requesters 0–3 all valid continuously -> grants 0,1,2,3,0 on consecutive cycles. Each `rsp_valid[i]` arrives one cycle after its grant.
- Write 0xDEADBEEF to address 3 at T, requester 2 reads address 3 at T+1 -> `rsp_data=0xDEADBEEF` at T+2.
- Same-cycle write 0x12345678 to address 7 and read of address 7 (old value 0) -> response 0 without the macro, 0x12345678 with `BRAM_CTRL_WR_BYPASS_EN`.
- `clr` pulse in `S_RUN` with a read granted the same cycle -> that response is delivered. `init_done` falls, DEPTH zero writes follow, then previously written addresses read 0.
- `rst_n` asserted on the cycle after a grant -> `rsp_valid` is 0 immediately. After release, `rr_ptr` restarts at 0, so requester 0 wins the first grant when all are valid.
